// File: rtl/bus_sink_endpoint.sv
// Hub-side receiving endpoint: counted (cmd!=0) or isLast-terminated (cmd==0) messages into a FWFT FIFO.
// Optional received-word counter output enabled by defining BUS_SINK_WORDCOUNT_EN.
module bus_sink_endpoint #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] cmd,
   input  logic             cmd_isReady,
   output logic             cmd_canReceive,
   input  logic [63:0]      b_in,
   input  logic             b_in_isReady,
   output logic             b_in_canReceive,
   output logic             b_in_isLast_in,
   input  logic             b_in_isLast_out,
   output logic [63:0]      l_out,
   output logic             l_out_isReady,
   input  logic             l_out_canReceive,
   output logic             l_out_isLast
`ifdef BUS_SINK_WORDCOUNT_EN
   ,
   output logic [CNT_W-1:0] rcv_count
`endif
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic             auto_q, auto_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;

   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic [63:0]      mem_data_q [DEPTH];
   logic             mem_last_q [DEPTH];

   logic             empty_s, full_s, xfer_s, pop_s, cmd_acc_s, last_push_s, rem_one_s;

   assign empty_s   = (wr_ptr_q == rd_ptr_q);
   assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rem_one_s = (remaining_q == CNT_W'(1));

   assign cmd_canReceive  = (state_q == ST_IDLE);
   assign b_in_canReceive = (state_q == ST_RECV) && !full_s;
   assign b_in_isLast_in  = !auto_q && rem_one_s && b_in_canReceive;
   assign l_out_isReady   = !empty_s;

   assign cmd_acc_s   = cmd_isReady && (state_q == ST_IDLE);
   assign xfer_s      = b_in_isReady && b_in_canReceive;
   assign pop_s       = l_out_isReady && l_out_canReceive;
   // Counted mode ends on the count alone; the switch's resolved last only matters in auto mode.
   assign last_push_s = xfer_s && (auto_q ? b_in_isLast_out : rem_one_s);

   // Message FSM: next state, mode and remaining-word count.
   always_comb begin
      state_d     = state_q;
      auto_d      = auto_q;
      remaining_d = remaining_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_acc_s) begin
               state_d     = ST_RECV;
               auto_d      = (cmd == {CNT_W{1'b0}});
               remaining_d = cmd;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RECV: begin
            if (xfer_s) begin
               if (remaining_q != {CNT_W{1'b0}}) begin
                  remaining_d = remaining_q - CNT_W'(1);
               end else begin
                  remaining_d = remaining_q;
               end
               if (last_push_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_RECV;
               end
            end else begin
               state_d = ST_RECV;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         auto_q      <= 1'b0;
         remaining_q <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         auto_q      <= auto_d;
         remaining_q <= remaining_d;
      end
   end

   // FIFO storage and pointers; reset discards any buffered words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= {(AW+1){1'b0}};
         rd_ptr_q <= {(AW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_data_q[i] <= 64'd0;
            mem_last_q[i] <= 1'b0;
         end
      end else begin
         if (xfer_s) begin
            mem_data_q[wr_ptr_q[AW-1:0]] <= b_in;
            mem_last_q[wr_ptr_q[AW-1:0]] <= last_push_s;
            wr_ptr_q                     <= wr_ptr_q + (AW+1)'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
         end
      end
   end

   // First-word-fall-through head; zero while empty so stale entries never show.
   always_comb begin
      if (empty_s) begin
         l_out        = 64'd0;
         l_out_isLast = 1'b0;
      end else begin
         l_out        = mem_data_q[rd_ptr_q[AW-1:0]];
         l_out_isLast = mem_last_q[rd_ptr_q[AW-1:0]];
      end
   end

`ifdef BUS_SINK_WORDCOUNT_EN
   logic [CNT_W-1:0] rcv_count_q;

   // Words received in the current message, saturating at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rcv_count_q <= {CNT_W{1'b0}};
      end else if (cmd_acc_s) begin
         rcv_count_q <= {CNT_W{1'b0}};
      end else if (xfer_s && (rcv_count_q != {CNT_W{1'b1}})) begin
         rcv_count_q <= rcv_count_q + CNT_W'(1);
      end
   end

   assign rcv_count = rcv_count_q;
`endif

endmodule

// File: tb/tb_bus_sink_endpoint.sv
// Directed bench for bus_sink_endpoint: counted, auto, backpressure, ignored cmd, async reset,
// and (with BUS_SINK_WORDCOUNT_EN) the received-word counter.
module tb_bus_sink_endpoint;

   localparam int CNT_W = 15;

   logic             clk = 1'b0;
   logic             rst;
   logic [CNT_W-1:0] cmd;
   logic             cmd_isReady;
   logic             cmd_canReceive;
   logic [63:0]      b_in;
   logic             b_in_isReady;
   logic             b_in_canReceive;
   logic             b_in_isLast_in;
   logic             b_in_isLast_out;
   logic [63:0]      l_out;
   logic             l_out_isReady;
   logic             l_out_canReceive;
   logic             l_out_isLast;
`ifdef BUS_SINK_WORDCOUNT_EN
   logic [CNT_W-1:0] rcv_count;
`endif

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;
   logic [63:0] w [0:7];

   bus_sink_endpoint #(.DEPTH(4), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .cmd              (cmd),
      .cmd_isReady      (cmd_isReady),
      .cmd_canReceive   (cmd_canReceive),
      .b_in             (b_in),
      .b_in_isReady     (b_in_isReady),
      .b_in_canReceive  (b_in_canReceive),
      .b_in_isLast_in   (b_in_isLast_in),
      .b_in_isLast_out  (b_in_isLast_out),
      .l_out            (l_out),
      .l_out_isReady    (l_out_isReady),
      .l_out_canReceive (l_out_canReceive),
      .l_out_isLast     (l_out_isLast)
`ifdef BUS_SINK_WORDCOUNT_EN
      ,
      .rcv_count        (rcv_count)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         w[i] = {16'hCAFE, 16'(i), 32'h8000_0000 ^ 32'(i * 7 + 1)};
      end
      rst = 1'b1; cmd = '0; cmd_isReady = 1'b0; b_in = 64'd0; b_in_isReady = 1'b0;
      b_in_isLast_out = 1'b0; l_out_canReceive = 1'b0;

      // Reset values
      @(negedge clk);
      chk("rst_cmd_canReceive", 64'(cmd_canReceive), 64'd1);
      chk("rst_b_in_canReceive", 64'(b_in_canReceive), 64'd0);
      chk("rst_isLast_in", 64'(b_in_isLast_in), 64'd0);
      chk("rst_l_out_isReady", 64'(l_out_isReady), 64'd0);
      chk("rst_l_out_isLast", 64'(l_out_isLast), 64'd0);
      chk("rst_l_out", l_out, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Test 1: counted, cmd=3, core always ready
      cmd = 15'd3; cmd_isReady = 1'b1; l_out_canReceive = 1'b1;
      step();
      cmd_isReady = 1'b0;
      chk("t1_cmd_canReceive_busy", 64'(cmd_canReceive), 64'd0);
      chk("t1_b_in_canReceive", 64'(b_in_canReceive), 64'd1);
      chk("t1_isLast_in_w0", 64'(b_in_isLast_in), 64'd0);
      b_in = w[0]; b_in_isReady = 1'b1;
      step();
      chk("t1_l_out_w0", l_out, w[0]);
      chk("t1_l_out_isLast_w0", 64'(l_out_isLast), 64'd0);
      chk("t1_isLast_in_w1", 64'(b_in_isLast_in), 64'd0);
      b_in = w[1];
      step();
      chk("t1_l_out_w1", l_out, w[1]);
      chk("t1_isLast_in_w2", 64'(b_in_isLast_in), 64'd1);
      b_in = w[2];
      step();
      b_in_isReady = 1'b0;
      chk("t1_l_out_w2", l_out, w[2]);
      chk("t1_l_out_isLast_w2", 64'(l_out_isLast), 64'd1);
      chk("t1_cmd_canReceive_after", 64'(cmd_canReceive), 64'd1);
      chk("t1_b_in_canReceive_after", 64'(b_in_canReceive), 64'd0);
      chk("t1_isLast_in_after", 64'(b_in_isLast_in), 64'd0);
      step();
      chk("t1_drained", 64'(l_out_isReady), 64'd0);

      // Test 2: auto mode, 5 words, resolved last on word 5
      cmd = 15'd0; cmd_isReady = 1'b1;
      step();
      cmd_isReady = 1'b0;
      for (int k = 0; k < 5; k++) begin
         b_in = w[k]; b_in_isReady = 1'b1; b_in_isLast_out = (k == 4);
         chk("t2_isLast_in", 64'(b_in_isLast_in), 64'd0);
         step();
         chk("t2_l_out", l_out, w[k]);
         chk("t2_l_out_isLast", 64'(l_out_isLast), 64'(k == 4));
      end
      b_in_isReady = 1'b0; b_in_isLast_out = 1'b0;
      chk("t2_cmd_canReceive", 64'(cmd_canReceive), 64'd1);
      step();
      chk("t2_drained", 64'(l_out_isReady), 64'd0);

      // Test 3: backpressure, cmd=6, DEPTH=4
      l_out_canReceive = 1'b0;
      cmd = 15'd6; cmd_isReady = 1'b1;
      step();
      cmd_isReady = 1'b0;
      for (int k = 0; k < 4; k++) begin
         b_in = w[k]; b_in_isReady = 1'b1;
         chk("t3_canReceive_fill", 64'(b_in_canReceive), 64'd1);
         step();
      end
      b_in = w[4];
      chk("t3_canReceive_full", 64'(b_in_canReceive), 64'd0);
      chk("t3_head_w0", l_out, w[0]);
      l_out_canReceive = 1'b1;
      step();
      l_out_canReceive = 1'b0;
      chk("t3_canReceive_after_pop", 64'(b_in_canReceive), 64'd1);
      chk("t3_head_w1", l_out, w[1]);
      step();
      chk("t3_canReceive_full_again", 64'(b_in_canReceive), 64'd0);
      chk("t3_head_w1_hold", l_out, w[1]);
      b_in = w[5]; l_out_canReceive = 1'b1;
      step();
      chk("t3_canReceive_w5", 64'(b_in_canReceive), 64'd1);
      chk("t3_isLast_in_w5", 64'(b_in_isLast_in), 64'd1);
      chk("t3_head_w2", l_out, w[2]);
      step();
      b_in_isReady = 1'b0;
      chk("t3_head_w3", l_out, w[3]);
      chk("t3_cmd_canReceive", 64'(cmd_canReceive), 64'd1);
      step();
      chk("t3_head_w4", l_out, w[4]);
      chk("t3_isLast_w4", 64'(l_out_isLast), 64'd0);
      step();
      chk("t3_head_w5", l_out, w[5]);
      chk("t3_isLast_w5", 64'(l_out_isLast), 64'd1);
      step();
      chk("t3_drained", 64'(l_out_isReady), 64'd0);

      // Test 4: cmd pulsed while receiving is ignored
      cmd = 15'd2; cmd_isReady = 1'b1;
      step();
      cmd = 15'd9; b_in = w[6]; b_in_isReady = 1'b1;
      step();
      chk("t4_cmd_canReceive_busy", 64'(cmd_canReceive), 64'd0);
      chk("t4_isLast_in", 64'(b_in_isLast_in), 64'd1);
      chk("t4_head_w6", l_out, w[6]);
      b_in = w[7];
      step();
      cmd_isReady = 1'b0; b_in_isReady = 1'b0;
      chk("t4_head_w7", l_out, w[7]);
      chk("t4_isLast_w7", 64'(l_out_isLast), 64'd1);
      chk("t4_cmd_canReceive_idle", 64'(cmd_canReceive), 64'd1);
      chk("t4_b_in_canReceive_idle", 64'(b_in_canReceive), 64'd0);
      step();
      chk("t4_drained", 64'(l_out_isReady), 64'd0);
      chk("t4_still_idle", 64'(cmd_canReceive), 64'd1);

      // Test 5: asynchronous reset mid-message
      l_out_canReceive = 1'b0;
      cmd = 15'd5; cmd_isReady = 1'b1;
      step();
      cmd_isReady = 1'b0;
      b_in = w[0]; b_in_isReady = 1'b1;
      step();
      b_in = w[1];
      step();
      b_in_isReady = 1'b0;
      chk("t5_two_buffered", l_out, w[0]);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_l_out_isReady", 64'(l_out_isReady), 64'd0);
      chk("t5_rst_l_out", l_out, 64'd0);
      chk("t5_rst_cmd_canReceive", 64'(cmd_canReceive), 64'd1);
      chk("t5_rst_b_in_canReceive", 64'(b_in_canReceive), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      l_out_canReceive = 1'b1;
      cmd = 15'd1; cmd_isReady = 1'b1;
      step();
      cmd_isReady = 1'b0;
      b_in = w[3]; b_in_isReady = 1'b1;
      chk("t5_isLast_in", 64'(b_in_isLast_in), 64'd1);
      step();
      b_in_isReady = 1'b0;
      chk("t5_head_w3", l_out, w[3]);
      chk("t5_isLast_w3", 64'(l_out_isLast), 64'd1);
      chk("t5_cmd_canReceive", 64'(cmd_canReceive), 64'd1);
      step();
      chk("t5_drained", 64'(l_out_isReady), 64'd0);

`ifdef BUS_SINK_WORDCOUNT_EN
      // Test 6: word counter in auto mode
      cmd = 15'd0; cmd_isReady = 1'b1;
      step();
      cmd_isReady = 1'b0;
      chk("t6_count_cleared", 64'(rcv_count), 64'd0);
      for (int k = 0; k < 7; k++) begin
         b_in = w[k]; b_in_isReady = 1'b1; b_in_isLast_out = (k == 6);
         step();
      end
      b_in_isReady = 1'b0; b_in_isLast_out = 1'b0;
      chk("t6_count_7", 64'(rcv_count), 64'd7);
      step();
      step();
      chk("t6_count_hold", 64'(rcv_count), 64'd7);
      cmd = 15'd3; cmd_isReady = 1'b1;
      step();
      cmd_isReady = 1'b0;
      chk("t6_count_new_cmd", 64'(rcv_count), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
